// File: rtl/i2c_slave_rx_frontend.sv
// rtl/i2c_slave_rx_frontend.sv - I2C slave receive front end: sync, deglitch, START/STOP detect, byte shifter
// Feeds the slave control FSM with condition pulses and completed bytes; armed by byte_receiver_enable.
module i2c_slave_rx_frontend #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       SCL_in,
   input  logic       SDA_in,
   input  logic       byte_receiver_enable,
   output logic       scl_f,
   output logic       sda_f,
   output logic       scl_rise,
   output logic       scl_fall,
   output logic       Start_Condition,
   output logic       Stop_Condition,
   output logic       bus_busy,
   output logic [7:0] received_byte,
   output logic       done_receiving
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0] FL_M1 = CW'(FILTER_LEN - 1);

   typedef enum logic {R_IDLE = 1'b0, R_SHIFT = 1'b1} rx_state_e;

   // Index 0 is SCL, index 1 is SDA.
   logic [1:0]             raw_pins;
   logic [SYNC_STAGES-1:0] sync_q [2];
   logic [CW-1:0]          fcnt_q [2];
   logic [1:0]             filt_q;
   logic [1:0]             prev_q;

   logic scl_rise_q, scl_fall_q, start_q, stop_q, busy_q;
   logic scl_rise_d, scl_fall_d, start_d, stop_d, scl_held_d;

   rx_state_e  rx_state_q;
   logic [2:0] bit_cnt_q;
   logic [6:0] sh_q;
   logic [7:0] rx_byte_q;
   logic       done_q;
   logic       rearm_ok_q;

   assign raw_pins = {SDA_in, SCL_in};

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < 2; i++) begin
            sync_q[i] <= '1;
            fcnt_q[i] <= '0;
         end
         filt_q <= 2'b11;
         prev_q <= 2'b11;
      end else begin
         for (int i = 0; i < 2; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw_pins[i]};
            // A level is accepted only after FILTER_LEN consecutive disagreeing samples.
            if (sync_q[i][SYNC_STAGES-1] != filt_q[i]) begin
               if (fcnt_q[i] == FL_M1) begin
                  filt_q[i] <= sync_q[i][SYNC_STAGES-1];
                  fcnt_q[i] <= '0;
               end else begin
                  fcnt_q[i] <= fcnt_q[i] + CW'(1);
               end
            end else begin
               fcnt_q[i] <= '0;
            end
         end
         prev_q <= filt_q;
      end
   end

   // SCL stable high across both cycles rules out simultaneous SCL/SDA changes.
   assign scl_held_d = prev_q[0] & filt_q[0];
   assign scl_rise_d = ~prev_q[0] & filt_q[0];
   assign scl_fall_d = prev_q[0] & ~filt_q[0];
   assign start_d    = scl_held_d & prev_q[1] & ~filt_q[1];
   assign stop_d     = scl_held_d & ~prev_q[1] & filt_q[1];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         scl_rise_q <= 1'b0;
         scl_fall_q <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         scl_rise_q <= scl_rise_d;
         scl_fall_q <= scl_fall_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
         if (start_d) begin
            busy_q <= 1'b1;
         end else if (stop_d) begin
            busy_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rx_state_q <= R_IDLE;
         bit_cnt_q  <= 3'd0;
         sh_q       <= 7'd0;
         rx_byte_q  <= 8'h00;
         done_q     <= 1'b0;
         rearm_ok_q <= 1'b1;
      end else begin
         done_q <= 1'b0;
         if (!byte_receiver_enable) begin
            rearm_ok_q <= 1'b1;
         end
         if (start_q) begin
            bit_cnt_q  <= 3'd0;
            sh_q       <= 7'd0;
            rx_state_q <= byte_receiver_enable ? R_SHIFT : R_IDLE;
         end else if (stop_q) begin
            bit_cnt_q  <= 3'd0;
            rx_state_q <= R_IDLE;
         end else begin
            case (rx_state_q)
               R_IDLE: begin
                  if (byte_receiver_enable && rearm_ok_q) begin
                     bit_cnt_q  <= 3'd0;
                     rx_state_q <= R_SHIFT;
                  end
               end
               R_SHIFT: begin
                  if (!byte_receiver_enable) begin
                     bit_cnt_q  <= 3'd0;
                     rx_state_q <= R_IDLE;
                  end else if (scl_rise_q) begin
                     sh_q <= {sh_q[5:0], filt_q[1]};
                     if (bit_cnt_q == 3'd7) begin
                        rx_byte_q  <= {sh_q, filt_q[1]};
                        done_q     <= 1'b1;
                        bit_cnt_q  <= 3'd0;
                        rx_state_q <= R_IDLE;
                        rearm_ok_q <= 1'b0;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                     end
                  end
               end
               default: rx_state_q <= R_IDLE;
            endcase
         end
      end
   end

   assign scl_f           = filt_q[0];
   assign sda_f           = filt_q[1];
   assign scl_rise        = scl_rise_q;
   assign scl_fall        = scl_fall_q;
   assign Start_Condition = start_q;
   assign Stop_Condition  = stop_q;
   assign bus_busy        = busy_q;
   assign received_byte   = rx_byte_q;
   assign done_receiving  = done_q;

endmodule
